arch_state_dumper: RTL and testbench
====================================

# arch_state_dumper

Sequential read-out engine that sits on the testbench control side of the CPU and drives its register-file and data-memory backdoor read ports. On a `start` pulse it walks all architectural registers, then a programmable data-memory window, and streams every word out through a valid/ready port to the checker or scoreboard. This lets end-of-test architectural state be compared without hierarchical peeks.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register address width.
- `NUM_REGS`, 32: registers dumped, indices 0..NUM_REGS-1.
- `DMEM_AW`, 10: data-memory word address width (1024 words).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a dump; sampled only in IDLE.
- `dmem_base` in DMEM_AW: first memory word address; latched on accepted `start`.
- `dmem_len` in DMEM_AW+1: number of memory words, 0..1024; latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the last word has been accepted downstream.
- `tb_reg_rd_addr` out REG_ADDR_W: register read address.
- `tb_reg_rd_data` in 32: register data, combinational, valid in the same cycle as the address.
- `tb_dmem_re` out 1: memory read strobe.
- `tb_dmem_addr` out DMEM_AW: memory read address.
- `tb_dmem_rdata` in 32: memory data, valid exactly one cycle after `tb_dmem_re`.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out 32: dumped word.
- `out_kind` out 1: 0 = register, 1 = memory.
- `out_idx` out DMEM_AW: register index, or memory offset from base (0..len-1).

## Operation
- States: IDLE, REGS, MEM, DRAIN.
- IDLE + `start`: latch base and len, clear counters, go to REGS. `start` in any other state is ignored.
- Output path is a 2-entry FIFO holding {kind, idx, data}. `out_*` reflect the FIFO head.
- Credit rule: define `free = 2 - occupancy_after_this_cycle's_pop - inflight`. A read may issue only when free ≥ 1.
- REGS:
  - Each cycle with credit, drive `tb_reg_rd_addr = reg_idx` and push {0, reg_idx, `tb_reg_rd_data`} the same cycle, then increment `reg_idx`.
  - After pushing index NUM_REGS-1, go to MEM if len ≠ 0, else DRAIN.
- MEM:
  - Each cycle with credit, assert `tb_dmem_re` with `tb_dmem_addr = (base + mem_idx) mod 2^DMEM_AW` and set `inflight`.
  - Next cycle, push {1, mem_idx_of_that_read, `tb_dmem_rdata`}.
  - After issuing offset len-1, go to DRAIN.
- DRAIN: wait until FIFO is empty and no read is in flight, then pulse `done` and return to IDLE.
- Address wrap: base 1020 with len 8 reads 1020..1023, then 0..3. `out_idx` still counts 0..7.
- `tb_dmem_re` is low whenever no read issues. `tb_reg_rd_addr` holds its last value outside REGS.
- `rst` in any state returns to IDLE, flushes the FIFO, drops any in-flight read, and pulses no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_kind`=0, `out_idx`=0, `tb_dmem_re`=0, `tb_dmem_addr`=0, `tb_reg_rd_addr`=0.
- `start` sampled high at edge T: `busy` high from T+1, first register read at T+1, `out_valid` high at T+2.
- Memory latency: read at cycle C lands in the FIFO at C+1. It is visible on `out_*` at C+2 if the FIFO was empty.
- Throughput: 1 word/cycle with `out_ready` held high, including across the REGS→MEM transition.
- `out_valid` with stable payload is held while `out_ready` is low.
- `done` and `busy` fall together, one cycle after the final handshake.
- Total dump with `out_ready` held high: NUM_REGS + len words, `done` at T + NUM_REGS + len + 2.

## Test plan
- Reset state: hold `rst` 3 cycles -> all outputs 0, `start` during reset ignored.
- Register-only dump: regs preloaded r[i]=0x100+i, len=0, `out_ready`=1 -> 32 words in consecutive cycles, kind 0, idx 0..31, data 0x100..0x11F. `done` pulse exactly once, no `tb_dmem_re`.
- Full dump with wrap: base=1022, len=4, mem[a]=0xA000+a -> after registers, data 0xA3FE, 0xA3FF, 0xA000, 0xA001 with idx 0..3. `tb_dmem_addr` sequence is 1022, 1023, 0, 1.
- Backpressure: `out_ready` toggled randomly (50%) during the full dump -> no lost or duplicated word, order identical to the unstalled run. FIFO never overflows (≤ 2 entries plus 1 in flight).
- Max length: len=1024, base=0 -> 1056 words total, last idx 1023, `done` at T+1058 with ready high.
- Mid-operation reset / ignored start: `rst` during MEM -> `out_valid`=0 the next cycle, no `done`. A new `start` after reset gives a clean full dump. `start` pulses while busy do not restart the sequence.

Source files
------------

// File: rtl/arch_state_dumper.sv
// arch_state_dumper: end-of-test read-out engine. Walks every architectural
// register through the combinational register backdoor, then a wrapping
// window of data memory through the one-cycle-latency memory backdoor, and
// streams each word as {kind, idx, data} through a 2-entry output FIFO.
module arch_state_dumper #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int DMEM_AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DMEM_AW-1:0]    dmem_base,
  input  logic [DMEM_AW:0]      dmem_len,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] tb_reg_rd_addr,
  input  logic [31:0]           tb_reg_rd_data,
  output logic                  tb_dmem_re,
  output logic [DMEM_AW-1:0]    tb_dmem_addr,
  input  logic [31:0]           tb_dmem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_kind,
  output logic [DMEM_AW-1:0]    out_idx
);

  typedef enum logic [1:0] {S_IDLE, S_REGS, S_MEM, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DMEM_AW-1:0]    r_base;
  logic [DMEM_AW:0]      r_len;
  logic [REG_ADDR_W-1:0] r_reg_idx;
  logic [DMEM_AW:0]      r_mem_idx;

  // Memory read issued last cycle; its data is on tb_dmem_rdata this cycle.
  logic                  r_inflight_p1;
  logic [DMEM_AW-1:0]    r_inflight_idx_p1;

  // Output FIFO: entry 0 is the head, entry 1 the tail slot.
  logic [1:0]            r_count;
  logic                  r_kind0, r_kind1;
  logic [DMEM_AW-1:0]    r_idx0, r_idx1;
  logic [31:0]           r_data0, r_data1;

  logic                  w_pop;
  logic [1:0]            w_occ_after_pop;
  logic [2:0]            w_used;
  logic                  w_credit1;
  logic                  w_credit2;
  logic                  w_reg_last;
  logic                  w_mem_last;
  logic                  w_reg_push;
  logic                  w_issue;
  logic                  w_done;
  logic                  w_push;
  logic                  w_push_kind;
  logic [DMEM_AW-1:0]    w_push_idx;
  logic [31:0]           w_push_data;

  // Credit: slots left after this cycle's pop, minus the word still in flight.
  always_comb begin
    w_pop           = (r_count != 2'd0) && out_ready;
    w_occ_after_pop = r_count - {1'b0, w_pop};
    w_used          = {1'b0, w_occ_after_pop} + {2'b00, r_inflight_p1};
    w_credit1       = (w_used <= 3'd1);
    w_credit2       = (w_used == 3'd0);
    w_reg_last      = (r_reg_idx == REG_ADDR_W'(NUM_REGS - 1));
    w_mem_last      = (r_mem_idx == (r_len - 1'b1));
  end

  // Next state and read strobes. On the last register push the first memory
  // read is issued alongside it when two slots are free, so the stream keeps
  // one word per cycle across the register-to-memory hand-over.
  always_comb begin
    w_state_nxt = r_state;
    w_reg_push  = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_REGS;
      end
      S_REGS: begin
        if (w_credit1) begin
          w_reg_push = 1'b1;
          if (w_reg_last) begin
            if (r_len == '0) begin
              w_state_nxt = S_DRAIN;
            end else if (w_credit2) begin
              w_issue     = 1'b1;
              w_state_nxt = w_mem_last ? S_DRAIN : S_MEM;
            end else begin
              w_state_nxt = S_MEM;
            end
          end
        end
      end
      S_MEM: begin
        if (w_credit1) begin
          w_issue = 1'b1;
          if (w_mem_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_count == 2'd0) && !r_inflight_p1) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO write port: a landing memory word, else a register word.
  always_comb begin
    w_push      = w_reg_push | r_inflight_p1;
    w_push_kind = r_inflight_p1;
    w_push_idx  = r_inflight_p1 ? r_inflight_idx_p1 : DMEM_AW'(r_reg_idx);
    w_push_data = r_inflight_p1 ? tb_dmem_rdata : tb_reg_rd_data;
  end

  // Sequencer state, window latch, walk counters and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_base            <= '0;
      r_len             <= '0;
      r_reg_idx         <= '0;
      r_mem_idx         <= '0;
      r_inflight_p1     <= 1'b0;
      r_inflight_idx_p1 <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_inflight_p1 <= w_issue;
      if ((r_state == S_IDLE) && start) begin
        r_base    <= dmem_base;
        r_len     <= dmem_len;
        r_reg_idx <= '0;
        r_mem_idx <= '0;
      end
      if (w_reg_push && !w_reg_last) r_reg_idx <= r_reg_idx + 1'b1;
      if (w_issue) begin
        r_mem_idx         <= r_mem_idx + 1'b1;
        r_inflight_idx_p1 <= r_mem_idx[DMEM_AW-1:0];
      end
    end
  end

  // 2-entry FIFO; at most one push per cycle, credit guarantees no overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_kind0 <= 1'b0;
      r_kind1 <= 1'b0;
      r_idx0  <= '0;
      r_idx1  <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_kind0 <= w_push_kind;
            r_idx0  <= w_push_idx;
            r_data0 <= w_push_data;
          end else begin
            r_kind0 <= r_kind1;
            r_idx0  <= r_idx1;
            r_data0 <= r_data1;
            r_kind1 <= w_push_kind;
            r_idx1  <= w_push_idx;
            r_data1 <= w_push_data;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_kind0 <= w_push_kind;
            r_idx0  <= w_push_idx;
            r_data0 <= w_push_data;
          end else begin
            r_kind1 <= w_push_kind;
            r_idx1  <= w_push_idx;
            r_data1 <= w_push_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_kind0 <= r_kind1;
            r_idx0  <= r_idx1;
            r_data0 <= r_data1;
          end
          r_count <= r_count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = w_done;
  assign tb_reg_rd_addr = r_reg_idx;
  assign tb_dmem_re     = w_issue;
  assign tb_dmem_addr   = r_base + r_mem_idx[DMEM_AW-1:0];
  assign out_valid      = (r_count != 2'd0);
  assign out_kind       = r_kind0;
  assign out_idx        = r_idx0;
  assign out_data       = r_data0;

endmodule

// File: tb/tb_arch_state_dumper.sv
// Bench for arch_state_dumper: register file and data memory models, an
// expected word list built from the dump rules, and directed runs with
// random data and random output backpressure.
module tb_arch_state_dumper;
  localparam int NR = 32;
  localparam int AW = 10;
  localparam int RW = 5;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] dmem_base;
  logic [AW:0]   dmem_len;
  logic          busy;
  logic          done;
  logic [RW-1:0] tb_reg_rd_addr;
  logic [31:0]   tb_reg_rd_data;
  logic          tb_dmem_re;
  logic [AW-1:0] tb_dmem_addr;
  logic [31:0]   tb_dmem_rdata = 32'h0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_kind;
  logic [AW-1:0] out_idx;

  logic [31:0] regs [NR];
  logic [31:0] mem  [MW];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        kind;
    int          idx;
    logic [31:0] data;
  } word_t;

  arch_state_dumper #(.REG_ADDR_W(RW), .NUM_REGS(NR), .DMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .dmem_base(dmem_base), .dmem_len(dmem_len),
    .busy(busy), .done(done), .tb_reg_rd_addr(tb_reg_rd_addr), .tb_reg_rd_data(tb_reg_rd_data),
    .tb_dmem_re(tb_dmem_re), .tb_dmem_addr(tb_dmem_addr), .tb_dmem_rdata(tb_dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  assign tb_reg_rd_data = regs[tb_reg_rd_addr];

  always @(posedge clk) begin
    if (tb_dmem_re) tb_dmem_rdata <= mem[tb_dmem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete dump; the expected stream comes from the register array
  // followed by the memory window taken modulo the memory size.
  task automatic run_dump(input int base, input int len, input bit rand_ready,
                          input bit mid_start, input string nm);
    word_t       q[$];
    int          addrq[$];
    word_t       w;
    int          n;
    int          dones;
    int          done_n;
    int          extra_words;
    int          extra_re;
    bit          fin;
    logic [42:0] e;
    for (int i = 0; i < NR; i++) begin
      w.kind = 1'b0; w.idx = i; w.data = regs[i];
      q.push_back(w);
    end
    for (int j = 0; j < len; j++) begin
      w.kind = 1'b1; w.idx = j; w.data = mem[(base + j) % MW];
      q.push_back(w);
      addrq.push_back((base + j) % MW);
    end
    @(negedge clk);
    start = 1'b1; dmem_base = AW'(base); dmem_len = (AW+1)'(len); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({nm, "_busy_rise"}, {63'd0, busy}, 64'd1);
    chk({nm, "_valid_lat"}, {63'd0, out_valid}, 64'd0);
    chk({nm, "_first_raddr"}, {59'd0, tb_reg_rd_addr}, 64'd0);
    dones = 0; done_n = 0; extra_words = 0; extra_re = 0; fin = 1'b0;
    while (!fin && n < 6000) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) extra_words++;
        else begin
          w = q.pop_front();
          e = {w.kind, 10'(w.idx), w.data};
          chk({nm, "_word"}, {21'd0, out_kind, out_idx, out_data}, {21'd0, e});
        end
      end
      if (tb_dmem_re) begin
        if (addrq.size() == 0) extra_re++;
        else chk({nm, "_maddr"}, {54'd0, tb_dmem_addr}, 64'(addrq.pop_front()));
      end
      if (done) begin
        dones++;
        done_n = n;
        chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd1);
        fin = 1'b1;
      end
      start = (mid_start && n == 10) ? 1'b1 : 1'b0;
      if (mid_start && n == 10) begin
        dmem_base = AW'(base + 7); dmem_len = 11'd3;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({nm, "_busy_fall"}, {63'd0, busy}, 64'd0);
    chk({nm, "_done_single"}, {63'd0, done}, 64'd0);
    chk({nm, "_done_count"}, 64'(dones), 64'd1);
    chk({nm, "_missing_words"}, 64'(q.size()), 64'd0);
    chk({nm, "_extra_words"}, 64'(extra_words), 64'd0);
    chk({nm, "_missing_reads"}, 64'(addrq.size()), 64'd0);
    chk({nm, "_extra_reads"}, 64'(extra_re), 64'd0);
    if (!rand_ready) chk({nm, "_done_time"}, 64'(done_n), 64'(NR + len + 2));
  endtask

  initial begin
    int seen_re;
    int late_done;
    rst = 1'b1; start = 1'b1; dmem_base = 10'd5; dmem_len = 11'd3; out_ready = 1'b1;
    for (int i = 0; i < NR; i++) regs[i] = 32'h100 + i;
    for (int a = 0; a < MW; a++) mem[a] = 32'hA000 + a;

    // Reset held three cycles with start asserted.
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_payload", {21'd0, out_kind, out_idx, out_data}, 64'd0);
    chk("rst_re", {63'd0, tb_dmem_re}, 64'd0);
    chk("rst_maddr", {54'd0, tb_dmem_addr}, 64'd0);
    chk("rst_raddr", {59'd0, tb_reg_rd_addr}, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);

    // Register-only dump, then wrapped memory window.
    run_dump(0, 0, 1'b0, 1'b0, "regonly");
    run_dump(1022, 4, 1'b0, 1'b0, "wrap");

    // Random contents: unstalled, then random backpressure, then a start
    // pulse while busy that must be ignored.
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    for (int a = 0; a < MW; a++) mem[a] = $urandom;
    run_dump(1000, 40, 1'b0, 1'b0, "rand");
    run_dump(1000, 40, 1'b1, 1'b0, "stall");
    run_dump(int'($urandom_range(0, MW - 1)), int'($urandom_range(1, 60)), 1'b1, 1'b1, "midstart");

    // Maximum window.
    run_dump(0, 1024, 1'b0, 1'b0, "maxlen");

    // Reset during the memory phase.
    @(negedge clk);
    start = 1'b1; dmem_base = 10'd3; dmem_len = 11'd200;
    @(negedge clk);
    start = 1'b0;
    seen_re = 0;
    for (int k = 0; k < 200 && seen_re == 0; k++) begin
      if (tb_dmem_re) seen_re = 1;
      else @(negedge clk);
    end
    chk("midrst_reached_mem", 64'(seen_re), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_re", {63'd0, tb_dmem_re}, 64'd0);
    late_done = 0;
    for (int k = 0; k < 50; k++) begin
      if (done || out_valid) late_done++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(late_done), 64'd0);
    run_dump(1022, 4, 1'b0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
